// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared types and helpers for the multi-leg complementary PWM block.
//   - ch_state_t : per-leg gate FSM state (OFF, LO_ON, DEAD, HI_ON)
//   - clog2      : counter width helper. It never returns less than 1, so a
//                  degenerate range (PRESC=1, IRQ_DIV=1) still gets a 1-bit counter.
//   Derived widths used by the design modules:
//     PW  = clog2(PRESC)    prescaler counter width
//     DTW = clog2(DT + 1)   dead-time counter width
//     IW  = clog2(IRQ_DIV)  irq divider width
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_LO_ON = 2'd1,
    ST_DEAD  = 2'd2,
    ST_HI_ON = 2'd3
  } ch_state_t;

  localparam int STATE_W = 2;

  // Smallest w >= 1 with 2**w >= value.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pwm_multibridge_deadtime_channel.sv
// deadtime_channel
//   One half-bridge leg: turns the registered compare level `raw` into a
//   complementary gate pair with DT clocks of both-low between any two gate
//   changes. A raw pulse shorter than the dead time is swallowed, because the
//   dead-time count restarts whenever raw moves away from the pending target.
// Ports
//   clk    in   system clock
//   rst    in   asynchronous reset, active-high
//   ce     in   run enable; low forces OFF on the next clock
//   raw    in   registered compare level (1 = high side wanted)
//   hi     out  high-side gate, registered
//   lo     out  low-side gate, registered
//   state  out  current FSM state (debug)
module deadtime_channel
  import pwm_pkg::*;
#(
  parameter int DT = 50
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ce,
  input  logic      raw,
  output logic      hi,
  output logic      lo,
  output ch_state_t state
);

  localparam int DTW = clog2(DT + 1);

  ch_state_t      state_nx;
  logic           target;
  logic           target_nx;
  logic [DTW-1:0] dcnt;
  logic [DTW-1:0] dcnt_nx;

  // Gates are registered from the next state so they toggle cleanly on the
  // clock edge instead of being decoded from the state bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_OFF;
      target <= 1'b0;
      dcnt   <= '0;
      hi     <= 1'b0;
      lo     <= 1'b0;
    end else begin
      state  <= state_nx;
      target <= target_nx;
      dcnt   <= dcnt_nx;
      hi     <= (state_nx == ST_HI_ON);
      lo     <= (state_nx == ST_LO_ON);
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    dcnt_nx   = dcnt;
    if (!ce) begin
      state_nx = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          state_nx  = ST_DEAD;
          target_nx = raw;
          dcnt_nx   = '0;
        end
        ST_LO_ON: begin
          if (raw) begin
            state_nx  = ST_DEAD;
            target_nx = 1'b1;
            dcnt_nx   = '0;
          end
        end
        ST_HI_ON: begin
          if (!raw) begin
            state_nx  = ST_DEAD;
            target_nx = 1'b0;
            dcnt_nx   = '0;
          end
        end
        ST_DEAD: begin
          if (raw != target) begin
            // raw moved again before the dead time expired: restart it
            target_nx = raw;
            dcnt_nx   = '0;
          end else if (dcnt == DTW'(DT - 1)) begin
            state_nx = target ? ST_HI_ON : ST_LO_ON;
          end else begin
            dcnt_nx = dcnt + 1'b1;
          end
        end
        default: state_nx = ST_OFF;
      endcase
    end
  end

endmodule

// File: rtl/pwm_multibridge.sv
// pwm_multibridge
//   N-channel complementary PWM generator for multi-leg half-bridge inverters.
//   A shared prescaler drives a carrier counter 0..PERIOD-1. Each channel
//   compares the carrier against a double-buffered duty word (the shadow
//   reloads at the period wrap, or every clock while stopped). The registered
//   compare feeds a dead-time FSM per leg. irq pulses once every IRQ_DIV
//   periods.
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   ce         in   run enable; 0 = safe stop (gates low, counters held at 0)
//   duty       in   packed duty words, ch k = duty[k*DW +: DW], in carrier ticks
//   fault      in   async fault request, active-high    (PWM_FAULT_EN only)
//   fault_clr  in   clears the latched fault when fault=0 (PWM_FAULT_EN only)
//   out_hi     out  high-side gates, ch k = bit k
//   out_lo     out  low-side gates, ch k = bit k
//   irq        out  one-clock pulse at the period boundary
//   ch_state   out  per-channel FSM state, ch k = ch_state[2k +: 2] (debug)
// Build option
//   PWM_FAULT_EN : adds the fault/fault_clr ports and the fault latch. The
//                  default build has neither.
module pwm_multibridge
  import pwm_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int DW      = 10,
  parameter int PRESC   = 200,
  parameter int PERIOD  = 1000,
  parameter int DT      = 50,
  parameter int IRQ_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [N_CH*DW-1:0]      duty,
`ifdef PWM_FAULT_EN
  input  logic                    fault,
  input  logic                    fault_clr,
`endif
  output logic [N_CH-1:0]         out_hi,
  output logic [N_CH-1:0]         out_lo,
  output logic                    irq,
  output logic [STATE_W*N_CH-1:0] ch_state
);

  localparam int PW = clog2(PRESC);
  localparam int IW = clog2(IRQ_DIV);

  logic            run;
  logic [PW-1:0]   psc;
  logic [DW-1:0]   cnt;
  logic [IW-1:0]   idiv;
  logic            tick;
  logic            wrap;
  logic [DW-1:0]   duty_sh [N_CH];
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] hi_int;
  logic [N_CH-1:0] lo_int;

`ifdef PWM_FAULT_EN
  logic fault_lat;

  // fault sets the latch asynchronously; clearing is synchronous and only
  // honoured once the fault input itself has gone away.
  always_ff @(posedge clk or posedge rst or posedge fault) begin
    if (rst)            fault_lat <= 1'b0;
    else if (fault)     fault_lat <= 1'b1;
    else if (fault_clr) fault_lat <= 1'b0;
  end

  assign run    = ce & ~fault_lat;
  // Combinational gating so the gates drop without waiting for a clock edge.
  assign out_hi = hi_int & {N_CH{~(fault | fault_lat)}};
  assign out_lo = lo_int & {N_CH{~(fault | fault_lat)}};
`else
  assign run    = ce;
  assign out_hi = hi_int;
  assign out_lo = lo_int;
`endif

  assign tick = run && (psc == PW'(PRESC - 1));
  assign wrap = tick && (cnt == DW'(PERIOD - 1));

  // Prescaler, carrier and irq divider all sit at 0 while stopped, so a
  // restart always begins at the start of a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc  <= '0;
      cnt  <= '0;
      idiv <= '0;
      irq  <= 1'b0;
    end else if (!run) begin
      psc  <= '0;
      cnt  <= '0;
      idiv <= '0;
      irq  <= 1'b0;
    end else begin
      psc <= tick ? '0 : psc + 1'b1;
      if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
      irq <= wrap && (idiv == IW'(IRQ_DIV - 1));
      if (wrap) idiv <= (idiv == IW'(IRQ_DIV - 1)) ? '0 : idiv + 1'b1;
    end
  end

  // Shadow duty and registered compare. cnt never exceeds PERIOD-1, so a
  // shadow of PERIOD or more gives a constant 1 and a shadow of 0 a constant 0
  // without any special case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) duty_sh[k] <= '0;
      raw <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (!run || wrap) duty_sh[k] <= duty[k*DW +: DW];
        raw[k] <= (cnt < duty_sh[k]);
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ch_state_t st;

    deadtime_channel #(
      .DT(DT)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .ce   (run),
      .raw  (raw[k]),
      .hi   (hi_int[k]),
      .lo   (lo_int[k]),
      .state(st)
    );

    assign ch_state[STATE_W*k +: STATE_W] = st;
  end

endmodule

// File: tb/tb_pwm_multibridge.sv
// tb_pwm_multibridge
//   Bench for pwm_multibridge with N_CH=3, DW=4, PRESC=2, PERIOD=10, DT=3,
//   IRQ_DIV=2. The reference model works at waveform level: the carrier is a
//   function of the number of run cycles, the compare level is cnt < shadow,
//   and a gate is on when the last DT+1 compare samples since start all agree.
//   Build option PWM_FAULT_EN adds the fault sequence.
module tb_pwm_multibridge;

  localparam int N_CH    = 3;
  localparam int DW      = 4;
  localparam int PRESC   = 2;
  localparam int PERIOD  = 10;
  localparam int DT      = 3;
  localparam int IRQ_DIV = 2;
  localparam int EW      = 1 + 2 * N_CH;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic [N_CH*DW-1:0] duty;
  logic fault     = 1'b0;
  logic fault_clr = 1'b0;
  logic [N_CH-1:0]   out_hi;
  logic [N_CH-1:0]   out_lo;
  logic              irq;
  logic [2*N_CH-1:0] ch_state;

  always #5 clk = ~clk;

  pwm_multibridge #(
    .N_CH(N_CH), .DW(DW), .PRESC(PRESC), .PERIOD(PERIOD), .DT(DT), .IRQ_DIV(IRQ_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .duty     (duty),
`ifdef PWM_FAULT_EN
    .fault    (fault),
    .fault_clr(fault_clr),
`endif
    .out_hi   (out_hi),
    .out_lo   (out_lo),
    .irq      (irq),
    .ch_state (ch_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  // reference model state (values after the latest clock edge)
  int            m_p;
  int            m_cnt;
  int            m_nv;
  logic          m_lat;
  logic [DW-1:0] m_dsh  [N_CH];
  logic [N_CH-1:0] m_raw;
  logic [DT:0]   m_hist [N_CH];

  // waveform monitors
  logic prev_hi [N_CH];
  logic prev_lo [N_CH];
  int   lowcnt   [N_CH];
  int   hi_run   [N_CH];
  int   lo_run   [N_CH];
  int   last_hi_w[N_CH];
  int   last_lo_w[N_CH];
  int   hi_cnt   [N_CH];
  int   irq_cnt;

  task automatic model_step();
    logic [N_CH-1:0] new_raw;
    logic [N_CH-1:0] e_hi;
    logic [N_CH-1:0] e_lo;
    logic            e_irq;
    logic            run_now;
    if (rst) begin
      m_p = 0; m_cnt = 0; m_nv = 0; m_lat = 1'b0; m_raw = '0;
      for (int k = 0; k < N_CH; k++) begin
        m_dsh[k] = '0;
        m_hist[k] = '0;
      end
      exp_q.push_back('0);
    end else begin
      run_now = ce && !m_lat && !fault;
      for (int k = 0; k < N_CH; k++) new_raw[k] = (m_cnt < int'(m_dsh[k]));
      if (run_now) begin
        m_p++;
        if (m_nv < DT + 1) m_nv++;
        for (int k = 0; k < N_CH; k++) m_hist[k] = {m_hist[k][DT-1:0], m_raw[k]};
      end else begin
        m_p  = 0;
        m_nv = 0;
      end
      for (int k = 0; k < N_CH; k++) begin
        e_hi[k] = (m_nv == DT + 1) && (&m_hist[k]);
        e_lo[k] = (m_nv == DT + 1) && !(|m_hist[k]);
      end
      e_irq = run_now && (m_p % (PRESC * PERIOD * IRQ_DIV) == 0);
      m_cnt = (m_p / PRESC) % PERIOD;
      if (!run_now || (m_p % (PRESC * PERIOD) == 0))
        for (int k = 0; k < N_CH; k++) m_dsh[k] = duty[k*DW +: DW];
      m_raw = new_raw;
      if (fault)          m_lat = 1'b1;
      else if (fault_clr) m_lat = 1'b0;
      exp_q.push_back({e_irq, e_hi, e_lo});
    end
  endtask

  task automatic check_cycle();
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    o = {irq, out_hi, out_lo};
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%b required=an expected entry", o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL sb t=%0t {irq,hi,lo} observed=%b expected=%b", $time, o, e);
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      n_assert++;
      assert (!(out_hi[k] && out_lo[k])) else begin
        n_fail++;
        $error("FAIL overlap ch%0d observed hi=%b lo=%b expected not both 1", k, out_hi[k], out_lo[k]);
      end
      if ((out_hi[k] && !prev_hi[k]) || (out_lo[k] && !prev_lo[k])) begin
        n_assert++;
        assert (lowcnt[k] >= DT) else begin
          n_fail++;
          $error("FAIL deadtime ch%0d observed=%0d expected>=%0d", k, lowcnt[k], DT);
        end
      end
      lowcnt[k] = (out_hi[k] || out_lo[k]) ? 0 : lowcnt[k] + 1;
      if (out_hi[k]) begin
        hi_run[k]++;
        hi_cnt[k]++;
      end else if (prev_hi[k]) begin
        last_hi_w[k] = hi_run[k];
        hi_run[k] = 0;
      end
      if (out_lo[k]) begin
        lo_run[k]++;
      end else if (prev_lo[k]) begin
        last_lo_w[k] = lo_run[k];
        lo_run[k] = 0;
      end
      prev_hi[k] = out_hi[k];
      prev_lo[k] = out_lo[k];
    end
    if (irq) irq_cnt++;
  endtask

  // driver: one clock, model on the rising edge, compare on the falling edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b0;
    duty = '0;
    irq_cnt = 0;
    for (int k = 0; k < N_CH; k++) begin
      prev_hi[k] = 1'b0; prev_lo[k] = 1'b0; lowcnt[k] = DT;
      hi_run[k] = 0; lo_run[k] = 0; last_hi_w[k] = 0; last_lo_w[k] = 0; hi_cnt[k] = 0;
    end

    // reset state
    tick(3);
    check("rst_outputs", {25'd0, irq, out_hi, out_lo}, 32'd0);
    check("rst_ch_state", {26'd0, ch_state}, 32'd0);
    rst = 1'b0;
    tick(2);

    // duty {ch2=10, ch1=0, ch0=5}: ch0 50%, ch1 low side const, ch2 high side const
    duty = {4'd10, 4'd0, 4'd5};
    tick(1);
    ce = 1'b1;
    irq_cnt = 0;
    tick(80);
    check("irq_count_80", irq_cnt, 2);
    check("ch0_hi_width_d5", last_hi_w[0], 7);
    check("ch0_lo_width_d5", last_lo_w[0], 7);
    check("ch1_lo_const", {31'd0, out_lo[1]}, 1);
    check("ch1_hi_never", hi_cnt[1], 0);
    check("ch2_hi_const", {31'd0, out_hi[2]}, 1);

    // mid-period duty change 5 -> 7 takes effect from the next period
    tick(5);
    duty = {4'd10, 4'd0, 4'd7};
    tick(11);
    check("ch0_hi_width_old", last_hi_w[0], 7);
    tick(25);
    check("ch0_hi_width_new", last_hi_w[0], 11);

    // duty 1: 2-clock raw pulse is shorter than the dead time
    duty = {4'd10, 4'd0, 4'd1};
    tick(20);
    hi_cnt[0] = 0;
    irq_cnt = 0;
    tick(40);
    check("ch0_short_pulse_no_hi", hi_cnt[0], 0);
    check("ch0_short_pulse_lo_w", last_lo_w[0], 15);
    check("irq_count_40", irq_cnt, 1);

    // ce=0 mid-period: outputs low in one clock, counters idle, no irq
    duty = {4'd10, 4'd0, 4'd5};
    tick(5);
    ce = 1'b0;
    tick(1);
    check("stop_outputs", {25'd0, irq, out_hi, out_lo}, 32'd0);
    irq_cnt = 0;
    tick(30);
    check("stop_no_irq", irq_cnt, 0);

    // restart from cnt=0; ch0 reaches HI_ON after the dead time
    ce = 1'b1;
    tick(6);
    check("restart_ch0_hi", {31'd0, out_hi[0]}, 1);

    // asynchronous reset while ch0 is high
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_hi", {29'd0, out_hi}, 0);
    check("async_rst_lo", {29'd0, out_lo}, 0);
    tick(3);
    rst = 1'b0;
    irq_cnt = 0;
    tick(60);
    check("post_rst_irq", irq_cnt, 1);

`ifdef PWM_FAULT_EN
    // fault forces gates low at once and holds them until a valid clear
    #2;
    fault = 1'b1;
    #1;
    check("fault_async_hi", {29'd0, out_hi}, 0);
    check("fault_async_lo", {29'd0, out_lo}, 0);
    tick(3);
    fault_clr = 1'b1;
    tick(2);
    fault = 1'b0;
    fault_clr = 1'b0;
    tick(4);
    check("fault_latched", {29'd0, out_hi | out_lo}, 0);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    tick(40);
    check("fault_restart_ch2_hi", {31'd0, out_hi[2]}, 1);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout observed=no finish expected=finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
